// File: rtl/bnn_pkg.sv
// bnn_pkg: shared constants and FSM encoding for the BNN layer scheduler.
// Holds the layer geometry (pixel and output counts), bus widths, the
// scheduler state encoding and small per-layer lookup helpers.
package bnn_pkg;

  localparam int K       = 5;
  localparam int KK      = 25;
  localparam int IMG_W0  = 28;
  localparam int IMG_W1  = 12;
  localparam int NPIX0   = 784;
  localparam int NPIX1   = 144;
  localparam int NOUT0   = 576;
  localparam int NOUT1   = 64;
  localparam int PIX_W   = 8;
  localparam int PADDR_W = 10;
  // Two 25-bit kernels sit back to back at addresses 0..49.
  // Reaching address 49 takes six address bits.
  localparam int WADDR_W = 6;
  localparam int CNT_W   = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_STREAM,
    ST_DRAIN,
    ST_FIN
  } sched_state_t;

  // Number of input pixels streamed for the selected layer.
  function automatic logic [CNT_W-1:0] layer_npix(input logic l);
    return l ? CNT_W'(NPIX1) : CNT_W'(NPIX0);
  endfunction

  // Number of conv output beats a correct run produces for the layer.
  function automatic logic [CNT_W-1:0] layer_nout(input logic l);
    return l ? CNT_W'(NOUT1) : CNT_W'(NOUT0);
  endfunction

endpackage

// File: rtl/bnn_conv_sched_if.sv
// bnn_conv_sched_if: bundle of every scheduler signal except clk/rst.
// Covers the layer-sequencer handshake (start/layer/busy/done/err/res_count),
// the pixel buffer and weight ROM read ports, and the window/conv links.
// master = scheduler side, slave = surrounding environment.
interface bnn_conv_sched_if;
  import bnn_pkg::*;

  logic               start;
  logic               layer;
  logic               busy;
  logic               done;
  logic               err;
  logic [CNT_W-1:0]   res_count;
  logic               pix_rden;
  logic [PADDR_W-1:0] pix_raddr;
  logic [PIX_W-1:0]   pix_rdata;
  logic               w_rden;
  logic [WADDR_W-1:0] w_raddr;
  logic               w_rdata;
  logic               win_start;
  logic [PIX_W-1:0]   win_din;
  logic               win_state;
  logic               conv_start;
  logic               conv_weight_en;
  logic               conv_weight;
  logic               conv_state;
  logic               conv_ovalid;
  logic               conv_done;

  modport master (
    input  start, layer, pix_rdata, w_rdata, conv_ovalid, conv_done,
    output busy, done, err, res_count, pix_rden, pix_raddr, w_rden, w_raddr,
           win_start, win_din, win_state, conv_start, conv_weight_en,
           conv_weight, conv_state
  );

  modport slave (
    output start, layer, pix_rdata, w_rdata, conv_ovalid, conv_done,
    input  busy, done, err, res_count, pix_rden, pix_raddr, w_rden, w_raddr,
           win_start, win_din, win_state, conv_start, conv_weight_en,
           conv_weight, conv_state
  );

endinterface

// File: rtl/bnn_rd_stream.sv
// bnn_rd_stream: generic addressed-read sequencer.
// A pulse on i_go issues i_len reads on consecutive cycles starting at
// i_base (o_rden/o_addr). o_valid marks the cycle each read's data is
// present on a 1-cycle-latency memory; o_last flags the final one.
// Ports: clk, rst (sync, active high), i_go, i_base, i_len,
//        o_rden, o_addr, o_valid, o_last.
module bnn_rd_stream #(
  parameter int AW = 10,
  parameter int LW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_go,
  input  logic [AW-1:0] i_base,
  input  logic [LW-1:0] i_len,
  output logic          o_rden,
  output logic [AW-1:0] o_addr,
  output logic          o_valid,
  output logic          o_last
);

  logic          r_active;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_left;
  logic          r_valid;
  logic          r_last;

  // r_left counts reads remaining after the current one, so the read
  // issued while it is zero is the last. valid/last trail rden by one
  // cycle to line up with the memory's registered data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_addr   <= '0;
      r_left   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      r_valid <= r_active;
      r_last  <= r_active && (r_left == '0);
      if (i_go) begin
        r_active <= 1'b1;
        r_addr   <= i_base;
        r_left   <= i_len - LW'(1);
      end else if (r_active) begin
        if (r_left == '0) begin
          r_active <= 1'b0;
        end else begin
          r_addr <= r_addr + AW'(1);
          r_left <= r_left - LW'(1);
        end
      end
    end
  end

  assign o_rden  = r_active;
  assign o_addr  = r_addr;
  assign o_valid = r_valid;
  assign o_last  = r_last;

endmodule

// File: rtl/bnn_conv_sched.sv
// bnn_conv_sched: per-layer scheduler for the BNN window/conv pair.
// Loads the 25-bit kernel of the selected layer into conv, streams the
// layer's input pixels into window, counts conv output beats and reports
// done/err. Ports: clk, rst (sync, active high), bus (master modport of
// bnn_conv_sched_if carrying all handshake, memory and engine signals).
module bnn_conv_sched
  import bnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  bnn_conv_sched_if.master  bus
);

  sched_state_t     r_state;
  logic             r_layer;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_early;
  logic [CNT_W-1:0] r_count;

  logic               w_accept;
  logic [WADDR_W-1:0] w_wBase;
  logic               w_wRden;
  logic [WADDR_W-1:0] w_wAddr;
  logic               w_wValid;
  logic               w_wLast;
  logic               w_pGo;
  logic               w_pRden;
  logic [PADDR_W-1:0] w_pAddr;
  logic               w_pValid;
  logic               w_pLast;
  logic [CNT_W-1:0]   w_countNext;

  // The weight reader starts on the accept edge itself so its first read
  // lines up with busy rising; base comes from the live layer input.
  assign w_accept = (r_state == ST_IDLE) && bus.start;
  assign w_wBase  = bus.layer ? WADDR_W'(KK) : '0;
  assign w_pGo    = (r_state == ST_LOAD_W) && w_wValid && w_wLast;

  bnn_rd_stream #(.AW(WADDR_W), .LW(CNT_W)) u_wRd (
    .clk     (clk),
    .rst     (rst),
    .i_go    (w_accept),
    .i_base  (w_wBase),
    .i_len   (CNT_W'(KK)),
    .o_rden  (w_wRden),
    .o_addr  (w_wAddr),
    .o_valid (w_wValid),
    .o_last  (w_wLast)
  );

  bnn_rd_stream #(.AW(PADDR_W), .LW(CNT_W)) u_pRd (
    .clk     (clk),
    .rst     (rst),
    .i_go    (w_pGo),
    .i_base  ('0),
    .i_len   (layer_npix(r_layer)),
    .o_rden  (w_pRden),
    .o_addr  (w_pAddr),
    .o_valid (w_pValid),
    .o_last  (w_pLast)
  );

  // Saturating output-beat count; only beats seen while busy are counted.
  assign w_countNext = (r_busy && bus.conv_ovalid && (r_count != '1)) ?
                       r_count + CNT_W'(1) : r_count;

  // The count is cleared on accept and otherwise holds its last value
  // so the sequencer can read it after done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= '0;
    end else begin
      r_count <= w_countNext;
    end
  end

  // Layer FSM. A conv_done seen while pixels are still streaming is
  // remembered in r_early: streaming still finishes, DRAIN then falls
  // straight through, and err is forced at completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_layer <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_early <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_layer <= bus.layer;
            r_err   <= 1'b0;
            r_early <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD_W;
          end
        end
        ST_LOAD_W: begin
          if (w_pGo) r_state <= ST_STREAM;
        end
        ST_STREAM: begin
          if (bus.conv_done) r_early <= 1'b1;
          if (w_pValid && w_pLast) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (bus.conv_done || r_early) begin
            r_done  <= 1'b1;
            r_err   <= r_early || (w_countNext != layer_nout(r_layer));
            r_state <= ST_FIN;
          end
        end
        ST_FIN: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.err            = r_err;
  assign bus.res_count      = r_count;
  assign bus.w_rden         = w_wRden;
  assign bus.w_raddr        = w_wAddr;
  assign bus.conv_weight_en = w_wValid;
  assign bus.conv_weight    = w_wValid & bus.w_rdata;
  assign bus.pix_rden       = w_pRden;
  assign bus.pix_raddr      = w_pAddr;
  // Memory data is already registered; gating keeps win_din quiet between pixels.
  assign bus.win_din        = w_pValid ? bus.pix_rdata : '0;
  assign bus.win_start      = (r_state == ST_STREAM) || (r_state == ST_DRAIN);
  assign bus.conv_start     = (r_state == ST_STREAM) || (r_state == ST_DRAIN);
  assign bus.win_state      = r_layer;
  assign bus.conv_state     = r_layer;

endmodule

// File: tb/tb_bnn_conv_sched.sv
// tb_bnn_conv_sched: directed self-checking bench for bnn_conv_sched.
// Models the pixel buffer (ramp), the weight ROM and a simple conv engine
// that emits a chosen number of output beats and a conv_done pulse.
module tb_bnn_conv_sched;
  import bnn_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [PIX_W-1:0] pixMem [1024];
  logic             wRom   [64];

  bnn_conv_sched_if bus ();

  bnn_conv_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Both memories have one cycle of read latency.
  always @(posedge clk) begin
    if (bus.pix_rden) bus.pix_rdata <= pixMem[bus.pix_raddr];
    if (bus.w_rden)   bus.w_rdata   <= wRom[bus.w_raddr];
  end

  task automatic test_reset();
    logic [63:0] outs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    outs = {bus.busy, bus.done, bus.err, bus.res_count, bus.pix_rden,
            bus.pix_raddr, bus.w_rden, bus.w_raddr, bus.win_start, bus.win_din,
            bus.win_state, bus.conv_start, bus.conv_weight_en, bus.conv_weight,
            bus.conv_state};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %0h want 0", outs);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.res_count !== '0) begin
      bad++;
      $display("[TB] FAIL post_reset_idle: got busy=%0b cnt=%0d want 0/0", bus.busy, bus.res_count);
    end
  endtask

  task automatic test_idle_ovalid();
    bus.conv_ovalid = 1'b1;
    repeat (3) @(negedge clk);
    bus.conv_ovalid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.res_count !== '0) begin
      bad++;
      $display("[TB] FAIL idle_ovalid_count: got %0d want 0", bus.res_count);
    end
  endtask

  // Runs one layer from an IDLE-cycle negedge. Optionally pulses start
  // mid-run and in the done cycle, or asserts rst once pixel rstAt is read.
  task automatic run_layer(input bit L, input int nOv, input bit early,
                           input bit injStart, input int rstAt, input bit expErr,
                           input string tag);
    int nPix, expCnt, cyc, wRd, wBeat, wBad, wAddrBad, firstWen, lastWen;
    int firstPr, pRd, pAddrBad, pWin, pBad, lastWin, ovSent, doneCyc, stBad;
    int prevPIdx;
    bit prevPr, cdSent, expW, expCs;
    logic [63:0] outs;
    nPix = L ? NPIX1 : NPIX0;
    expCnt = L ? NOUT1 : NOUT0;
    wRd = 0; wBeat = 0; wBad = 0; wAddrBad = 0; firstWen = -1; lastWen = -1;
    firstPr = -1; pRd = 0; pAddrBad = 0; pWin = 0; pBad = 0; lastWin = -1;
    ovSent = 0; doneCyc = -1; stBad = 0; prevPIdx = 0; prevPr = 0; cdSent = 0;

    bus.layer = L;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;

    total++;
    if (bus.busy !== 1'b1 || bus.w_rden !== 1'b1 || bus.res_count !== '0) begin
      bad++;
      $display("[TB] FAIL %s accept: got busy=%0b rden=%0b cnt=%0d want 1/1/0", tag, bus.busy, bus.w_rden, bus.res_count);
    end

    for (cyc = 1; cyc <= 1200; cyc++) begin
      if (bus.w_rden) begin
        if (bus.w_raddr !== WADDR_W'(L * 25 + wRd)) wAddrBad++;
        wRd++;
      end
      if (bus.conv_weight_en) begin
        expW = L ? ((wBeat % 2) == 0) : 1'b1;
        if (bus.conv_weight !== expW) wBad++;
        if (firstWen < 0) firstWen = cyc;
        lastWen = cyc;
        wBeat++;
      end
      if (prevPr) begin
        if (bus.win_din !== PIX_W'(prevPIdx)) pBad++;
        pWin++;
        lastWin = cyc;
      end
      prevPr = bus.pix_rden;
      if (bus.pix_rden) begin
        if (bus.pix_raddr !== PADDR_W'(pRd)) pAddrBad++;
        prevPIdx = pRd;
        if (firstPr < 0) firstPr = cyc;
        pRd++;
      end
      expCs = (cyc >= 27);
      if (bus.win_state !== L || bus.conv_state !== L) stBad++;
      if (cyc <= 27 + nPix && (bus.conv_start !== expCs || bus.win_start !== expCs)) stBad++;

      if (rstAt >= 0 && pRd == rstAt) begin
        bus.conv_ovalid = 1'b0;
        bus.conv_done = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        outs = {bus.busy, bus.done, bus.err, bus.res_count, bus.pix_rden,
                bus.pix_raddr, bus.w_rden, bus.w_raddr, bus.win_start, bus.win_din,
                bus.win_state, bus.conv_start, bus.conv_weight_en, bus.conv_weight,
                bus.conv_state};
        total++;
        if (outs !== '0) begin
          bad++;
          $display("[TB] FAIL %s midrun_reset_outputs: got %0h want 0", tag, outs);
        end
        rst = 1'b0;
        return;
      end

      if (bus.done === 1'b1) begin
        doneCyc = cyc;
        total++;
        if (bus.busy !== 1'b1) begin
          bad++;
          $display("[TB] FAIL %s busy_at_done: got %0b want 1", tag, bus.busy);
        end
        bus.conv_ovalid = 1'b0;
        bus.conv_done = 1'b0;
        bus.start = injStart;
        break;
      end

      bus.start = injStart && (cyc == 10);
      bus.conv_ovalid = 1'b0;
      if (cyc >= 27 && ovSent < nOv) begin
        bus.conv_ovalid = 1'b1;
        ovSent++;
      end
      bus.conv_done = 1'b0;
      if (!cdSent) begin
        if (early && pRd >= 300) begin
          bus.conv_done = 1'b1;
          cdSent = 1;
        end else if (!early && lastWin > 0 && cyc > lastWin && ovSent >= nOv) begin
          bus.conv_done = 1'b1;
          cdSent = 1;
        end
      end
      @(negedge clk);
    end

    total++;
    if (doneCyc < 0) begin
      bad++;
      $display("[TB] FAIL %s done_timeout: got none want cycle %0d", tag, 29 + nPix);
      bus.conv_ovalid = 1'b0;
      bus.conv_done = 1'b0;
    end
    total++;
    if (doneCyc != 29 + nPix) begin
      bad++;
      $display("[TB] FAIL %s done_cycle: got %0d want %0d", tag, doneCyc, 29 + nPix);
    end
    total++;
    if (wRd != 25 || wAddrBad != 0) begin
      bad++;
      $display("[TB] FAIL %s weight_reads: got %0d reads %0d bad addr want 25/0", tag, wRd, wAddrBad);
    end
    total++;
    if (wBeat != 25 || wBad != 0) begin
      bad++;
      $display("[TB] FAIL %s weight_beats: got %0d beats %0d bad bits want 25/0", tag, wBeat, wBad);
    end
    total++;
    if (firstWen != 2 || lastWen != 26 || firstPr != 27) begin
      bad++;
      $display("[TB] FAIL %s load_timing: got wen %0d..%0d pix %0d want 2..26 27", tag, firstWen, lastWen, firstPr);
    end
    total++;
    if (pRd != nPix || pAddrBad != 0) begin
      bad++;
      $display("[TB] FAIL %s pixel_reads: got %0d reads %0d bad addr want %0d/0", tag, pRd, pAddrBad, nPix);
    end
    total++;
    if (pWin != nPix || pBad != 0 || lastWin != 27 + nPix) begin
      bad++;
      $display("[TB] FAIL %s win_din: got %0d beats %0d bad last %0d want %0d/0/%0d", tag, pWin, pBad, lastWin, nPix, 27 + nPix);
    end
    total++;
    if (stBad != 0) begin
      bad++;
      $display("[TB] FAIL %s state_start_lines: got %0d bad cycles want 0", tag, stBad);
    end
    total++;
    if (bus.res_count !== CNT_W'(nOv) || bus.err !== expErr) begin
      bad++;
      $display("[TB] FAIL %s result: got cnt=%0d err=%0b want %0d/%0b", tag, bus.res_count, bus.err, nOv, expErr);
    end
    if (nOv == expCnt && !early) begin
      total++;
      if (bus.err !== 1'b0) begin
        bad++;
        $display("[TB] FAIL %s clean_err: got %0b want 0", tag, bus.err);
      end
    end
  endtask

  task automatic test_layer0();
    run_layer(1'b0, 576, 1'b0, 1'b0, -1, 1'b0, "layer0");
    @(negedge clk);
  endtask

  task automatic test_layer1();
    run_layer(1'b1, 64, 1'b0, 1'b0, -1, 1'b0, "layer1");
    @(negedge clk);
  endtask

  task automatic test_short_count();
    run_layer(1'b0, 575, 1'b0, 1'b0, -1, 1'b1, "short_count");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_layer(1'b0, 576, 1'b0, 1'b1, -1, 1'b0, "b2b_first");
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_done_cycle_start: got busy=%0b done=%0b want 0/0", bus.busy, bus.done);
    end
    total++;
    if (bus.res_count !== CNT_W'(576)) begin
      bad++;
      $display("[TB] FAIL b2b_hold_count: got %0d want 576", bus.res_count);
    end
    run_layer(1'b1, 64, 1'b0, 1'b0, -1, 1'b0, "b2b_second");
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    run_layer(1'b0, 576, 1'b0, 1'b0, 300, 1'b0, "rst_midrun");
    run_layer(1'b0, 576, 1'b0, 1'b0, -1, 1'b0, "after_rst");
    @(negedge clk);
  endtask

  task automatic test_early_done();
    run_layer(1'b0, 576, 1'b1, 1'b0, -1, 1'b1, "early_done");
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) pixMem[i] = PIX_W'(i);
    for (int i = 0; i < 64; i++) begin
      if (i < 25)      wRom[i] = 1'b1;
      else if (i < 50) wRom[i] = ((i - 25) % 2) == 0;
      else             wRom[i] = 1'b0;
    end
    total = 0;
    bad = 0;
    clk = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.layer = 1'b0;
    bus.conv_ovalid = 1'b0;
    bus.conv_done = 1'b0;
    bus.pix_rdata = '0;
    bus.w_rdata = 1'b0;

    test_reset();
    test_idle_ovalid();
    test_layer0();
    test_layer1();
    test_short_count();
    test_back_to_back();
    test_reset_midrun();
    test_early_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
